syscall_string_printer: RTL

Services the print-string syscall (v0 == 4) on behalf of the pipeline. It accepts the string start address that the syscall handler drives on sig_print_string, then reads data memory word by word. It emits the NUL-terminated string one character per cycle and holds the pipeline stalled until the terminator is found.

---
 rtl/syscall_string_printer_pkg.sv | 19 +
 rtl/syscall_string_printer_byte_lane_select.sv | 25 ++
 rtl/syscall_string_printer.sv | 116 +++++++++++
 3 files changed

// File: rtl/syscall_string_printer_pkg.sv
// Shared types and constants for the print-string syscall service block.
package syscall_string_printer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [WORD_W-1:0] SYSCALL_PRINT_INT  = 32'd1;
    localparam logic [WORD_W-1:0] SYSCALL_PRINT_STR  = 32'd4;
    localparam logic [WORD_W-1:0] SYSCALL_EXIT       = 32'd10;
    localparam logic [WORD_W-1:0] SYSCALL_PRINT_CHAR = 32'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/syscall_string_printer_byte_lane_select.sv
// Picks one byte out of a memory word by byte offset, honouring byte order.
module syscall_string_printer_byte_lane_select
    import syscall_string_printer_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        idx,
    output logic [BYTE_W-1:0] lane
);

    logic [1:0] lane_idx;

    // Big-endian puts offset 0 in the most significant byte.
    always_comb begin
        lane_idx = BIG_ENDIAN ? 2'(2'd3 - idx) : idx;
        case (lane_idx)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
    end

endmodule

// File: rtl/syscall_string_printer.sv
// Walks a NUL-terminated string in data memory and emits it one character
// per cycle, stalling the pipeline until the terminator or length cap.
module syscall_string_printer
    import syscall_string_printer_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 256,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter bit          SIM_PRINT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] sig_print_string,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              char_valid,
    output logic [BYTE_W-1:0] char_data,
    output logic              busy,
    output logic              done,
    output logic              truncated
);

    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    state_t            state;
    logic [WORD_W-1:0] word_buf;
    logic [1:0]        byte_idx;
    logic [CNT_W-1:0]  count;
    logic [BYTE_W-1:0] cur_byte;
    logic              at_limit;

    syscall_string_printer_byte_lane_select #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .word (word_buf),
        .idx  (byte_idx),
        .lane (cur_byte)
    );

    assign at_limit = (count == CNT_W'(MAX_LEN));

    // Character strobe comes straight from the EMIT state and buffered word.
    always_comb begin
        char_valid = (state == ST_EMIT) && (cur_byte != '0) && !at_limit;
        char_data  = char_valid ? cur_byte : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            truncated <= 1'b0;
            word_buf  <= '0;
            byte_idx  <= '0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sig_print_string != '0) begin
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= {sig_print_string[WORD_W-1:2], 2'b00};
                        byte_idx <= sig_print_string[1:0];
                        count    <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        word_buf <= mem_rdata;
                        mem_req  <= 1'b0;
                        state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // A NUL wins over the length cap, so a cap hit on NUL is not a truncation.
                    if (cur_byte == '0 || at_limit) begin
                        state     <= ST_FINISH;
                        done      <= 1'b1;
                        truncated <= (cur_byte != '0);
                    end else begin
                        count <= count + CNT_W'(1);
                        if (byte_idx == 2'd3) begin
                            byte_idx <= '0;
                            mem_addr <= mem_addr + WORD_W'(4);
                            mem_req  <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    truncated <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    if (SIM_PRINT) begin : g_print
`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (rst_n && char_valid) $write("%c", char_data);
        end
`endif
    end

endmodule
